// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the write-back arbiter.
// - Default geometry: FIFO depth, register data width, register index width.
// - Each queued entry holds a register index and its write data, {reg, data},
//   so one entry is WB_ADDR_W + WB_DATA_W bits wide.
// - free_slots(): the number of slots available for this cycle's enqueues. It
//   includes the slot that the same-cycle pop releases.
package wb_arbiter_pkg;

    localparam int unsigned WB_DEPTH   = 32'd4;
    localparam int unsigned WB_DATA_W  = 32'd16;
    localparam int unsigned WB_ADDR_W  = 32'd4;
    localparam int unsigned WB_ENTRY_W = WB_ADDR_W + WB_DATA_W;

    // The head is popped whenever the queue is non-empty, so its slot can be
    // reused in the same cycle.
    function automatic int unsigned free_slots(input int unsigned occ,
                                               input int unsigned depth);
        free_slots = depth - occ + ((occ != 32'd0) ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of write-back bus signals between the producers, the arbiter and the
// register-file write port.
//   Producer side : mem_valid/mem_reg/mem_data -> mem_ready
//                   alu_valid/alu_reg/alu_data -> alu_ready
//   Write port    : DstReg, WriteReg, DstData (registered)
//   Hazard info   : pending (one bit per register), count (FIFO occupancy)
// The slave modport belongs to the arbiter. The master modport belongs to the
// environment, which drives the requests and observes everything else.
interface wb_arbiter_if
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH  = WB_DEPTH,
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned ADDR_W = WB_ADDR_W
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 32'd1;
    localparam int unsigned NREG  = 32'd1 << ADDR_W;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_reg;
    logic [DATA_W-1:0] mem_data;
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic [ADDR_W-1:0] DstReg;
    logic              WriteReg;
    logic [DATA_W-1:0] DstData;
    logic [NREG-1:0]   pending;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data,
        output mem_ready, alu_ready, DstReg, WriteReg, DstData, pending, count
    );

    modport master (
        output mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data,
        input  mem_ready, alu_ready, DstReg, WriteReg, DstData, pending, count
    );

endinterface

// File: rtl/wb_fifo.sv
// Circular write-back queue with two write ports and one read port.
//   clk, rst           : clock, synchronous active-low reset
//   push0/reg0/data0   : first enqueue, which lands at the tail
//   push1/reg1/data1   : second enqueue, which lands just behind push0 when both
//                        ports are active
//   pop                : drop the head entry
//   head_reg/head_data : current head entry
//   count              : occupancy, 0..DEPTH
//   ent_valid/ent_reg  : per-slot occupancy and destination register
// The caller must never push beyond the free space or pop an empty queue.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH  = WB_DEPTH,
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned ADDR_W = WB_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push0,
    input  logic [ADDR_W-1:0]      reg0,
    input  logic [DATA_W-1:0]      data0,
    input  logic                   push1,
    input  logic [ADDR_W-1:0]      reg1,
    input  logic [DATA_W-1:0]      data1,
    input  logic                   pop,
    output logic [ADDR_W-1:0]      head_reg,
    output logic [DATA_W-1:0]      head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic [DEPTH-1:0]       ent_valid,
    output logic [ADDR_W-1:0]      ent_reg [DEPTH]
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 32'd1;

    logic [ADDR_W-1:0] reg_q  [DEPTH];
    logic [ADDR_W-1:0] reg_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  slot1_s;

    // Next-state for the storage, the pointers and the occupancy.
    always_comb begin
        reg_d   = reg_q;
        data_d  = data_q;
        // push1 shifts back one slot when push0 takes the tail.
        slot1_s = wptr_q + PTR_W'(push0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (push0 && (wptr_q == PTR_W'(i))) begin
                reg_d[i]  = reg0;
                data_d[i] = data0;
            end else if (push1 && (slot1_s == PTR_W'(i))) begin
                reg_d[i]  = reg1;
                data_d[i] = data1;
            end else begin
                reg_d[i]  = reg_q[i];
                data_d[i] = data_q[i];
            end
        end
        // Pointer arithmetic wraps naturally because DEPTH is a power of two.
        wptr_d  = wptr_q + PTR_W'(push0) + PTR_W'(push1);
        rptr_d  = rptr_q + PTR_W'(pop);
        count_d = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
    end

    // Storage, pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q  <= {PTR_W{1'b0}};
            rptr_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                reg_q[i]  <= {ADDR_W{1'b0}};
                data_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
        end
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        logic [PTR_W-1:0] off_v;
        for (int i = 0; i < int'(DEPTH); i++) begin
            off_v        = PTR_W'(i) - rptr_q;
            ent_valid[i] = ({1'b0, off_v} < count_q);
            ent_reg[i]   = reg_q[i];
        end
    end

    assign head_reg  = reg_q[rptr_q];
    assign head_data = data_q[rptr_q];
    assign count     = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter for the single write port of the register file.
//   clk, rst : clock, synchronous active-low reset
//   wb       : slave side of wb_arbiter_if, which carries the producer
//              handshakes, the registered write port (DstReg/WriteReg/DstData),
//              the pending-write mask and the FIFO occupancy
// The memory and ALU producers enqueue into wb_fifo, with memory ahead of the
// ALU in the same cycle. The head retires every cycle the queue is non-empty,
// because the register file never back-pressures.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH  = WB_DEPTH,
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned ADDR_W = WB_ADDR_W
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave wb
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 32'd1;
    localparam int unsigned NREG  = 32'd1 << ADDR_W;

    logic [CNT_W-1:0]  count_s;
    logic [DEPTH-1:0]  ent_valid_s;
    logic [ADDR_W-1:0] ent_reg_s [DEPTH];
    logic [ADDR_W-1:0] head_reg_s;
    logic [DATA_W-1:0] head_data_s;
    int unsigned       free_s;
    logic              pop_s;
    logic              mem_ready_s;
    logic              alu_ready_s;
    logic              push_mem_s;
    logic              push_alu_s;
    logic [NREG-1:0]   pending_s;

    logic              write_reg_q, write_reg_d;
    logic [ADDR_W-1:0] dst_reg_q, dst_reg_d;
    logic [DATA_W-1:0] dst_data_q, dst_data_d;

    function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] idx);
        onehot      = {NREG{1'b0}};
        onehot[idx] = 1'b1;
    endfunction

    // Ready and accept logic. The readies depend only on the occupancy and
    // mem_valid, so there is no loop through alu_valid. The ALU may take the
    // last free slot only when memory is not claiming it.
    always_comb begin
        free_s      = free_slots(32'(count_s), DEPTH);
        pop_s       = (count_s != {CNT_W{1'b0}});
        mem_ready_s = (free_s >= 32'd1);
        alu_ready_s = (free_s >= 32'd2) || ((free_s >= 32'd1) && !wb.mem_valid);
        push_mem_s  = wb.mem_valid && mem_ready_s;
        push_alu_s  = wb.alu_valid && alu_ready_s;
    end

    wb_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push0     (push_mem_s),
        .reg0      (wb.mem_reg),
        .data0     (wb.mem_data),
        .push1     (push_alu_s),
        .reg1      (wb.alu_reg),
        .data1     (wb.alu_data),
        .pop       (pop_s),
        .head_reg  (head_reg_s),
        .head_data (head_data_s),
        .count     (count_s),
        .ent_valid (ent_valid_s),
        .ent_reg   (ent_reg_s)
    );

    // Write-port next state. Index and data hold while the port is idle.
    always_comb begin
        write_reg_d = 1'b0;
        dst_reg_d   = dst_reg_q;
        dst_data_d  = dst_data_q;
        if (pop_s) begin
            write_reg_d = 1'b1;
            dst_reg_d   = head_reg_s;
            dst_data_d  = head_data_s;
        end else begin
            write_reg_d = 1'b0;
            dst_reg_d   = dst_reg_q;
            dst_data_d  = dst_data_q;
        end
    end

    // Registered write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            write_reg_q <= 1'b0;
            dst_reg_q   <= {ADDR_W{1'b0}};
            dst_data_q  <= {DATA_W{1'b0}};
        end else begin
            write_reg_q <= write_reg_d;
            dst_reg_q   <= dst_reg_d;
            dst_data_q  <= dst_data_d;
        end
    end

    // Pending mask: every queued destination, plus the one currently driven
    // on the write port. That write is not committed until the next edge.
    always_comb begin
        pending_s = {NREG{write_reg_q}} & onehot(dst_reg_q);
        for (int i = 0; i < int'(DEPTH); i++) begin
            pending_s = pending_s | ({NREG{ent_valid_s[i]}} & onehot(ent_reg_s[i]));
        end
    end

    assign wb.mem_ready = mem_ready_s;
    assign wb.alu_ready = alu_ready_s;
    assign wb.DstReg    = dst_reg_q;
    assign wb.WriteReg  = write_reg_q;
    assign wb.DstData   = dst_data_q;
    assign wb.pending   = pending_s;
    assign wb.count     = count_s;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter, with DEPTH=4, DATA_W=16 and ADDR_W=4.
module tb_wb_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    wb_arbiter_if #(.DEPTH(4), .DATA_W(16), .ADDR_W(4)) wb ();

    wb_arbiter #(.DEPTH(4), .DATA_W(16), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    always #5 clk = ~clk;

    // Register-file model: commits on the edge that follows a presented write.
    logic [15:0] rf [16];
    always @(posedge clk) begin
        if (wb.WriteReg) rf[wb.DstReg] <= wb.DstData;
    end

    // Retirement log, sampled on the falling edge (one entry per write cycle).
    logic [15:0] retired [$];
    always @(negedge clk) begin
        if (wb.WriteReg) retired.push_back(wb.DstData);
    end

    // Hand-derived saturation schedule: occupancy and alu_ready before edges 1..8.
    logic [2:0]  sat_cnt  [8]  = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
    logic        sat_ardy [8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [15:0] sat_exp  [11] = '{16'hA001, 16'hB001, 16'hA002, 16'hB002, 16'hA003,
                                   16'hB003, 16'hA004, 16'hA005, 16'hA006, 16'hA007,
                                   16'hA008};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mv, input logic [3:0] mr, input logic [15:0] md,
                         input logic av, input logic [3:0] ar, input logic [15:0] ad);
        wb.mem_valid = mv; wb.mem_reg = mr; wb.mem_data = md;
        wb.alu_valid = av; wb.alu_reg = ar; wb.alu_data = ad;
    endtask

    initial begin
        // Reset held for two edges while both producers request.
        rst = 1'b0;
        drive(1'b1, 4'd7, 16'h1111, 1'b1, 4'd8, 16'h2222);
        tick();
        tick();
        chk("rst_writereg", 32'(wb.WriteReg), 32'd0);
        chk("rst_dstreg",   32'(wb.DstReg),   32'd0);
        chk("rst_dstdata",  32'(wb.DstData),  32'd0);
        chk("rst_count",    32'(wb.count),    32'd0);
        chk("rst_pending",  32'(wb.pending),  32'd0);
        rst = 1'b1;
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
        #1;
        chk("rst_mem_ready", 32'(wb.mem_ready), 32'd1);
        chk("rst_alu_ready", 32'(wb.alu_ready), 32'd1);

        // Single ALU write R3 = 0x1234.
        drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 16'h1234);
        #1;
        chk("single_alu_ready", 32'(wb.alu_ready), 32'd1);
        tick();
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
        chk("single_q_count",   32'(wb.count),    32'd1);
        chk("single_q_pending", 32'(wb.pending),  32'h0008);
        chk("single_q_wr",      32'(wb.WriteReg), 32'd0);
        tick();
        chk("single_wr",      32'(wb.WriteReg), 32'd1);
        chk("single_dstreg",  32'(wb.DstReg),   32'd3);
        chk("single_dstdata", 32'(wb.DstData),  32'h1234);
        chk("single_pending", 32'(wb.pending),  32'h0008);
        tick();
        chk("single_idle_wr",      32'(wb.WriteReg), 32'd0);
        chk("single_idle_pending", 32'(wb.pending),  32'h0000);
        chk("single_idle_dstreg",  32'(wb.DstReg),   32'd3);
        chk("single_rf_r3",        32'(rf[3]),       32'h1234);

        // Same cycle, same register: memory first, then the ALU.
        drive(1'b1, 4'd5, 16'h8765, 1'b1, 4'd5, 16'hABCD);
        #1;
        chk("same_mem_ready", 32'(wb.mem_ready), 32'd1);
        chk("same_alu_ready", 32'(wb.alu_ready), 32'd1);
        tick();
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
        chk("same_count",   32'(wb.count),   32'd2);
        chk("same_pending", 32'(wb.pending), 32'h0020);
        tick();
        chk("same_wr1",   32'(wb.WriteReg), 32'd1);
        chk("same_reg1",  32'(wb.DstReg),   32'd5);
        chk("same_data1", 32'(wb.DstData),  32'h8765);
        tick();
        chk("same_wr2",   32'(wb.WriteReg), 32'd1);
        chk("same_data2", 32'(wb.DstData),  32'hABCD);
        chk("same_cnt2",  32'(wb.count),    32'd0);
        tick();
        chk("same_idle_wr", 32'(wb.WriteReg), 32'd0);
        chk("same_rf_r5",   32'(rf[5]),       32'hABCD);

        // Saturation: both producers valid for 8 cycles with distinct data.
        retired.delete();
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 4'(k), 16'hA000 + 16'(k), 1'b1, 4'(k + 8), 16'hB000 + 16'(k));
            #1;
            chk("sat_count",     32'(wb.count),     32'(sat_cnt[k-1]));
            chk("sat_alu_ready", 32'(wb.alu_ready), 32'(sat_ardy[k-1]));
            chk("sat_mem_ready", 32'(wb.mem_ready), 32'd1);
            tick();
        end
        chk("sat_full_count", 32'(wb.count), 32'd4);
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
        repeat (6) tick();
        chk("sat_drain_count", 32'(wb.count),    32'd0);
        chk("sat_drain_wr",    32'(wb.WriteReg), 32'd0);
        chk("sat_retired_len", 32'(retired.size()), 32'd11);
        for (int i = 0; i < 11; i++) begin
            if (i < retired.size()) chk("sat_order", 32'(retired[i]), 32'(sat_exp[i]));
            else chk("sat_order_missing", 32'(i), 32'(retired.size()));
        end

        // Fill to DEPTH so that only one slot is free.
        drive(1'b1, 4'd1, 16'hC001, 1'b1, 4'd2, 16'hC002);
        tick();
        drive(1'b1, 4'd3, 16'hC003, 1'b1, 4'd4, 16'hC004);
        tick();
        drive(1'b1, 4'd6, 16'hC006, 1'b1, 4'd7, 16'hC007);
        tick();
        chk("part_fill_count",   32'(wb.count),   32'd4);
        chk("part_fill_pending", 32'(wb.pending), 32'h00DC);
        drive(1'b1, 4'd8, 16'hC008, 1'b1, 4'd9, 16'hC009);
        #1;
        chk("part_mem_ready", 32'(wb.mem_ready), 32'd1);
        chk("part_alu_ready", 32'(wb.alu_ready), 32'd0);
        wb.mem_valid = 1'b0;
        #1;
        chk("part_alu_ready_nomem", 32'(wb.alu_ready), 32'd1);
        wb.mem_valid = 1'b1;
        tick();
        chk("part_count",   32'(wb.count),   32'd4);
        chk("part_pending", 32'(wb.pending), 32'h01D8);
        chk("part_dstreg",  32'(wb.DstReg),  32'd3);

        // Three entries queued (R6, R7, R8), then reset for one edge.
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
        tick();
        chk("mid_count",   32'(wb.count),   32'd3);
        chk("mid_pending", 32'(wb.pending), 32'h01D0);
        rst = 1'b0;
        drive(1'b1, 4'd10, 16'hC00A, 1'b0, 4'd0, 16'h0000);
        tick();
        retired.delete();
        chk("mid_rst_wr",      32'(wb.WriteReg), 32'd0);
        chk("mid_rst_count",   32'(wb.count),    32'd0);
        chk("mid_rst_pending", 32'(wb.pending),  32'h0000);
        chk("mid_rst_dstreg",  32'(wb.DstReg),   32'd0);
        chk("mid_rst_dstdata", 32'(wb.DstData),  32'd0);
        rst = 1'b1;
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
        repeat (4) tick();
        chk("mid_after_wr",      32'(wb.WriteReg), 32'd0);
        chk("mid_after_count",   32'(wb.count),    32'd0);
        chk("mid_after_retired", 32'(retired.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
